// File: rtl/sd_pkg.sv
// Shared definitions for the SD command-line response path: CRC7 polynomial,
// response frame bit positions and the receiver state encoding.
package sd_pkg;

  localparam logic [6:0] CRC7_POLY = 7'h09;  // x^7 + x^3 + 1

  localparam int unsigned START_BIT = 47;
  localparam int unsigned TX_BIT    = 46;
  localparam int unsigned INDEX_HI  = 45;
  localparam int unsigned INDEX_LO  = 40;
  localparam int unsigned ARG_HI    = 39;
  localparam int unsigned ARG_LO    = 8;
  localparam int unsigned CRC_HI    = 7;
  localparam int unsigned CRC_LO    = 1;
  localparam int unsigned END_BIT   = 0;

  typedef enum logic [1:0] {
    StIdle,
    StWaitStart,
    StRecv,
    StDone
  } rx_state_e;

  function automatic logic [6:0] crc7_step(input logic [6:0] crc, input logic bit_in);
    logic fb;
    fb = crc[6] ^ bit_in;
    return {crc[5:0], 1'b0} ^ (fb ? CRC7_POLY : 7'h00);
  endfunction

endpackage

// File: rtl/crc7_serial.sv
// Bit-serial CRC7 (x^7 + x^3 + 1), one bit per enabled cycle. Asserting clear
// together with enable folds the first bit into a zeroed register.
module crc7_serial
  import sd_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       clear,
  input  logic       enable,
  input  logic       bit_in,
  output logic [6:0] crc
);

  logic [6:0] crc_q;
  logic [6:0] base;

  always_comb base = clear ? 7'h00 : crc_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      crc_q <= 7'h00;
    end else if (enable) begin
      crc_q <= crc7_step(base, bit_in);
    end else if (clear) begin
      crc_q <= 7'h00;
    end
  end

  assign crc = crc_q;

endmodule

// File: rtl/sd_resp_rx.sv
// SD command-line response receiver: waits for the start bit (with timeout),
// shifts in a 48-bit frame MSB-first and checks CRC7 and framing bits.
module sd_resp_rx
  import sd_pkg::*;
#(
  parameter int unsigned FRAME_BITS     = 48,
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        check_crc,
  input  logic        cmd_in,
  output logic        busy,
  output logic        done,
  output logic [5:0]  resp_index,
  output logic [31:0] resp_arg,
  output logic [6:0]  crc_rx,
  output logic [6:0]  crc_calc,
  output logic        crc_error,
  output logic        frame_error,
  output logic        timeout
);

  localparam int unsigned CntW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam int unsigned IdxW = $clog2(FRAME_BITS);

  rx_state_e             state_q, state_d;
  logic [CntW-1:0]       wait_q, wait_d;
  logic [IdxW-1:0]       idx_q, idx_d;
  logic [FRAME_BITS-1:0] shift_q, shift_d;
  logic                  chk_q, chk_d;
  logic                  vld_q, vld_d;
  logic                  tmo_q, tmo_d;
  logic                  crc_clear, crc_en;
  logic [6:0]            crc_val;

  crc7_serial u_crc (
    .clk    (clk),
    .reset  (reset),
    .clear  (crc_clear),
    .enable (crc_en),
    .bit_in (cmd_in),
    .crc    (crc_val)
  );

  always_comb begin
    state_d   = state_q;
    wait_d    = wait_q;
    idx_d     = idx_q;
    shift_d   = shift_q;
    chk_d     = chk_q;
    vld_d     = vld_q;
    tmo_d     = tmo_q;
    crc_clear = 1'b0;
    crc_en    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StWaitStart;
          wait_d  = '0;
          chk_d   = check_crc;
          vld_d   = 1'b0;
          tmo_d   = 1'b0;
        end
      end
      StWaitStart: begin
        if (!cmd_in) begin
          // Start bit is frame bit 47: it enters both the shifter and the CRC.
          state_d   = StRecv;
          shift_d   = {shift_q[FRAME_BITS-2:0], cmd_in};
          idx_d     = IdxW'(START_BIT - 1);
          crc_clear = 1'b1;
          crc_en    = 1'b1;
        end else if (wait_q == CntW'(TIMEOUT_CYCLES - 1)) begin
          state_d = StDone;
          tmo_d   = 1'b1;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      StRecv: begin
        shift_d = {shift_q[FRAME_BITS-2:0], cmd_in};
        crc_en  = (idx_q >= IdxW'(ARG_LO));
        if (idx_q == '0) begin
          state_d = StDone;
          vld_d   = 1'b1;
        end else begin
          idx_d = idx_q - 1'b1;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
      wait_q  <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      chk_q   <= 1'b0;
      vld_q   <= 1'b0;
      tmo_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      chk_q   <= chk_d;
      vld_q   <= vld_d;
      tmo_q   <= tmo_d;
    end
  end

  assign busy       = (state_q != StIdle);
  assign done       = (state_q == StDone);
  assign resp_index = shift_q[INDEX_HI:INDEX_LO];
  assign resp_arg   = shift_q[ARG_HI:ARG_LO];
  assign crc_rx     = shift_q[CRC_HI:CRC_LO];
  assign crc_calc   = crc_val;
  assign timeout    = tmo_q;

  // Flags are gated by vld_q, which is only set by a completed frame and is
  // cleared when the next start is accepted, so a timeout reports them as 0.
  assign crc_error   = vld_q & chk_q & (shift_q[CRC_HI:CRC_LO] != crc_val);
  assign frame_error = vld_q & (shift_q[START_BIT] | shift_q[TX_BIT] | ~shift_q[END_BIT]);

endmodule

// File: tb/tb_sd_resp_rx.sv
// Self-checking bench for sd_resp_rx: directed vector table, hand-written
// timeout/reset/back-to-back sequences and random frames vs. a division model.
module tb_sd_resp_rx;

  localparam int unsigned TimeoutCycles = 64;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic        check_crc = 1'b0;
  logic        cmd_in = 1'b1;
  logic        busy, done, crc_error, frame_error, timeout;
  logic [5:0]  resp_index;
  logic [31:0] resp_arg;
  logic [6:0]  crc_rx, crc_calc;

  sd_resp_rx #(
    .FRAME_BITS     (48),
    .TIMEOUT_CYCLES (TimeoutCycles)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .check_crc   (check_crc),
    .cmd_in      (cmd_in),
    .busy        (busy),
    .done        (done),
    .resp_index  (resp_index),
    .resp_arg    (resp_arg),
    .crc_rx      (crc_rx),
    .crc_calc    (crc_calc),
    .crc_error   (crc_error),
    .frame_error (frame_error),
    .timeout     (timeout)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [47:0] frame;
    logic        chk;
    int          idle;
    logic [5:0]  idx;
    logic [31:0] arg;
    logic [6:0]  crx;
    logic [6:0]  ccalc;
    logic        cerr;
    logic        ferr;
  } vec_t;

  int    n_cmp = 0;
  int    n_err = 0;
  string cur = "init";
  vec_t  last;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL [%s] %s: got %0h, expected %0h", cur, name, act, exp);
    end
  endtask

  // CRC7 as the remainder of M(x)*x^7 divided by x^7 + x^3 + 1 (long division).
  function automatic logic [6:0] ref_crc(input logic [47:0] f);
    logic [46:0] r;
    r = {f[47:8], 7'b0};
    for (int i = 46; i >= 7; i--) begin
      if (r[i]) r[i-:8] = r[i-:8] ^ 8'h89;
    end
    return r[6:0];
  endfunction

  function automatic vec_t model(input logic [47:0] f, input logic chk, input int idle);
    vec_t v;
    v.frame = f;
    v.chk   = chk;
    v.idle  = idle;
    v.idx   = f[45:40];
    v.arg   = f[39:8];
    v.crx   = f[7:1];
    v.ccalc = ref_crc(f);
    v.cerr  = chk && (v.crx != v.ccalc);
    v.ferr  = f[46] || !f[0];
    return v;
  endfunction

  task automatic run_frame(input vec_t v, input logic hold);
    logic early;
    int   extra;
    early = 1'b0;
    @(negedge clk);
    check("idle before start", {busy, done}, 2'b00);
    start     = 1'b1;
    check_crc = v.chk;
    cmd_in    = 1'b1;
    for (int i = 0; i < v.idle; i++) begin
      @(negedge clk);
      start  = hold;
      cmd_in = 1'b1;
      early |= done;
    end
    for (int b = 47; b >= 0; b--) begin
      @(negedge clk);
      if (b == 47) check("busy after start", busy, 1'b1);
      start  = hold;
      cmd_in = v.frame[b];
      early |= done;
    end
    @(negedge clk);
    cmd_in = 1'b1;
    check("no early done", early, 1'b0);
    check("done latency", done, 1'b1);
    extra = 0;
    while (!done && extra < 100) begin
      @(negedge clk);
      extra++;
    end
    check("resp_index", resp_index, v.idx);
    check("resp_arg", resp_arg, v.arg);
    check("crc_rx", crc_rx, v.crx);
    check("crc_calc", crc_calc, v.ccalc);
    check("crc_error", crc_error, v.cerr);
    check("frame_error", frame_error, v.ferr);
    check("timeout", timeout, 1'b0);
    last = v;
  endtask

  vec_t vecs[5];

  initial begin
    vec_t v;
    int   cyc;
    logic seen;

    vecs[0] = '{48'h08_000001AA_13, 1'b1, 3, 6'd8, 32'h000001AA, 7'h09, 7'h09, 1'b0, 1'b0};
    vecs[1] = '{48'h08_000001AA_15, 1'b1, 3, 6'd8, 32'h000001AA, 7'h0A, 7'h09, 1'b1, 1'b0};
    vecs[2] = '{48'h08_000001AA_15, 1'b0, 3, 6'd8, 32'h000001AA, 7'h0A, 7'h09, 1'b0, 1'b0};
    vecs[3] = '{48'h08_000001AA_12, 1'b1, 3, 6'd8, 32'h000001AA, 7'h09, 7'h09, 1'b0, 1'b1};
    vecs[4] = '{48'h48_000001AA_13, 1'b1, 5, 6'd8, 32'h000001AA, 7'h09, 7'h43, 1'b1, 1'b1};

    cur = "reset";
    repeat (2) @(negedge clk);
    check("busy/done", {busy, done}, 2'b00);
    check("resp fields", {resp_index, resp_arg, crc_rx, crc_calc}, '0);
    check("flags", {crc_error, frame_error, timeout}, 3'b000);
    reset = 1'b1;

    for (int k = 0; k < 5; k++) begin
      cur = $sformatf("vec%0d", k);
      run_frame(vecs[k], 1'b0);
      if (k == 0) begin
        @(negedge clk);
        check("done single pulse", done, 1'b0);
        check("arg holds after done", resp_arg, 32'h000001AA);
      end
    end

    cur = "timeout";
    @(negedge clk);
    start  = 1'b1;
    cmd_in = 1'b1;
    cyc    = 0;
    seen   = 1'b0;
    while (!seen && cyc < 200) begin
      @(negedge clk);
      start = 1'b0;
      cyc++;
      seen = done;
    end
    check("timeout latency", cyc - 1, TimeoutCycles);
    check("timeout flag", timeout, 1'b1);
    check("flags cleared", {crc_error, frame_error}, 2'b00);
    check("fields hold", {resp_index, resp_arg, crc_rx, crc_calc},
          {last.idx, last.arg, last.crx, last.ccalc});

    cur = "start on last wait cycle";
    run_frame(model(48'h08_000001AA_13, 1'b1, TimeoutCycles - 1), 1'b0);

    cur = "reset mid-frame";
    @(negedge clk);
    start = 1'b1;
    for (int b = 47; b >= 28; b--) begin
      @(negedge clk);
      start  = 1'b0;
      cmd_in = vecs[0].frame[b];
    end
    @(negedge clk);
    reset  = 1'b0;
    cmd_in = 1'b1;
    #1;
    check("busy after reset", busy, 1'b0);
    check("crc_calc after reset", crc_calc, 7'h00);
    seen = done;
    repeat (4) begin
      @(negedge clk);
      seen |= done;
    end
    reset = 1'b1;
    repeat (3) begin
      @(negedge clk);
      seen |= done;
    end
    check("no done after reset", seen, 1'b0);
    run_frame(vecs[0], 1'b0);

    cur = "back-to-back";
    run_frame(model(48'h29_12345678_00 | 48'h1, 1'b1, 2), 1'b1);
    run_frame(vecs[0], 1'b1);
    start = 1'b0;

    for (int r = 0; r < 24; r++) begin
      logic [47:0] f;
      logic [6:0]  c;
      logic        txb, endb;
      cur  = $sformatf("random%0d", r);
      f    = {1'b0, 1'b0, 6'($urandom_range(0, 63)), 32'($urandom), 8'h00};
      c    = ($urandom_range(0, 3) != 0) ? ref_crc(f) : 7'($urandom);
      txb  = ($urandom_range(0, 7) == 0);
      endb = ($urandom_range(0, 7) != 0);
      f[46]  = txb;
      f[7:1] = c;
      f[0]   = endb;
      v = model(f, 1'($urandom_range(0, 1)), int'($urandom_range(0, 20)));
      run_frame(v, 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2ms;
    $display("FAIL [watchdog] simulation did not finish: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
